// File: rtl/sample_i2s_tx.sv
// sample_i2s_tx: buffers 16-bit mono samples in a small FIFO and serialises each
// one onto an I2S link, duplicated on left and right, with FIFO backpressure and flags.
module sample_i2s_tx #(
  parameter int CLK_DIV   = 10,
  parameter int SLOT_BITS = 25,
  parameter int DEPTH     = 8,
  parameter int PAUSE_LVL = 6
) (
  input  logic                       i_clk48,
  input  logic                       i_rst48,
  input  logic [15:0]                i_sample,
  input  logic                       i_pulse,
  input  logic                       i_clr_flags,
  output logic                       o_pause,
  output logic [$clog2(DEPTH+1)-1:0] o_fill,
  output logic                       o_underrun,
  output logic                       o_overrun,
  output logic                       o_bclk,
  output logic                       o_lrclk,
  output logic                       o_sdata
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [15:0]       word_q, word_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic              pause_q, pause_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];

  logic       fall;
  logic       pop;
  logic       pop_ok;
  logic       push_ok;
  logic       empty;
  logic       full;
  logic [3:0] sel;

  always_comb begin
    div_d      = div_q + DIV_W'(1);
    bclk_d     = bclk_q;
    fall       = 1'b0;
    bit_idx_d  = bit_idx_q;
    lrclk_d    = lrclk_q;
    word_d     = word_q;
    sdata_d    = sdata_q;
    pop        = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    sel        = 4'd0;

    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end

    // A slot wrap on the falling edge that enters the left channel starts a new frame.
    if (fall) begin
      if (bit_idx_q == BIT_W'(SLOT_BITS - 1)) begin
        bit_idx_d = '0;
        lrclk_d   = ~lrclk_q;
        pop       = lrclk_q;
      end else begin
        bit_idx_d = bit_idx_q + BIT_W'(1);
      end
    end

    empty   = (count_q == '0);
    full    = (count_q == FILL_W'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = i_pulse & (~full | pop_ok);

    if (pop) begin
      word_d = empty ? 16'h0000 : mem_q[rd_ptr_q];
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_sample;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + FILL_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - FILL_W'(1);
    end

    // Bit 0 is the I2S one-bit delay; bits 1..16 carry the word MSB first, the rest pad with zero.
    if (fall) begin
      sdata_d = 1'b0;
      if (bit_idx_d >= BIT_W'(1) && bit_idx_d <= BIT_W'(16)) begin
        sel     = 4'(BIT_W'(16) - bit_idx_d);
        sdata_d = word_d[sel];
      end
    end

    pause_d    = (count_d >= FILL_W'(PAUSE_LVL));
    underrun_d = (pop & empty) | (underrun_q & ~i_clr_flags);
    overrun_d  = (i_pulse & full & ~pop_ok) | (overrun_q & ~i_clr_flags);
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      bit_idx_q  <= BIT_W'(SLOT_BITS - 1);
      word_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pause_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      bit_idx_q  <= bit_idx_d;
      word_q     <= word_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pause_q    <= pause_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage needs no reset: pointers and count make stale entries unreachable.
  always_ff @(posedge i_clk48) begin
    mem_q <= mem_d;
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sdata    = sdata_q;
  assign o_fill     = count_q;
  assign o_pause    = pause_q;
  assign o_underrun = underrun_q;
  assign o_overrun  = overrun_q;

endmodule
